adc_max11331_s00_axi_regs: RTL

ADC_MAX11331_S00_AXI_REGS -- requirements
Module: adc_max11331_s00_axi_regs

---
 rtl/adc_max11331_s00_axi_regs.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/adc_max11331_s00_axi_regs.sv
// AXI4-Lite slave exposing four 32-bit control registers to the MAX11331 ADC core.
// Independent one-entry AW and W buffers; writes commit when both are full and no response is pending.
module adc_max11331_s00_axi_regs #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   slv_reg0,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   slv_reg1,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   slv_reg2,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   slv_reg3,
  output logic [3:0]                        reg_wr_pulse
);
  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int NB = C_S00_AXI_DATA_WIDTH / 8;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready depends only on internal state, never on the partner's valid.
  logic          rst_done;
  logic          aw_full;
  logic [1:0]    aw_idx;
  logic          w_full;
  logic [DW-1:0] w_data;
  logic [NB-1:0] w_strb;
  logic [DW-1:0] regs [4];
  logic          bvalid_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic          unused_bits;

  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_awready = rst_done & ~aw_full;
  assign s00_axi_wready  = rst_done & ~w_full;
  assign s00_axi_arready = rst_done & ~rvalid_q;
  assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
  assign w_hs   = s00_axi_wvalid & s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
  assign commit = aw_full & w_full & ~bvalid_q;

  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_rresp  = 2'b00;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rdata  = rdata_q;
  assign slv_reg0 = regs[0];
  assign slv_reg1 = regs[1];
  assign slv_reg2 = regs[2];
  assign slv_reg3 = regs[3];

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_full <= 1'b0;
      aw_idx  <= 2'd0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= s00_axi_awaddr[3:2];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
      bvalid_q     <= 1'b0;
      reg_wr_pulse <= 4'b0000;
    end else begin
      reg_wr_pulse <= 4'b0000;
      if (commit) begin
        for (int b = 0; b < NB; b++) begin
          if (w_strb[b]) begin
            regs[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
        bvalid_q     <= 1'b1;
        reg_wr_pulse <= 4'b0001 << aw_idx;
      end else if (bvalid_q && s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // rdata samples regs before any same-edge commit lands, so reads see the old value.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs[s00_axi_araddr[3:2]];
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end
endmodule
